// File: rtl/issue_ctrl.sv
// Issue control: scoreboard, divider interlock and serialising FSM in front of the execution pipes.
// Latency: issue/stall are combinational in the decode cycle; clear is registered. Backpressure: stall holds decode.
module issue_ctrl #(
    parameter int W_AA_REG   = 5,
    parameter int W_PD_POPS  = 3,
    parameter int W_STALLCNT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      CDI_PV_req,
    input  logic [W_PD_POPS-1:0]      CDI_PD_piops,
    input  logic [W_AA_REG-1:0]       CDI_AA_rd,
    input  logic [W_AA_REG-1:0]       CDI_AA_rs,
    input  logic [W_AA_REG-1:0]       CDI_AA_rt,
    input  logic                      CDI_PV_wb,
    input  logic [W_AA_REG-1:0]       CDI_AA_wb,
    input  logic                      CDI_PV_divdone,
    input  logic                      CDI_PV_sysdone,
    input  logic                      CFI_PC_redirect,
    output logic                      CFO_PC_stall,
    output logic                      CFO_PC_clear,
    output logic                      CFO_PV_issue,
    output logic [W_PD_POPS-1:0]      CFO_PD_piops,
    output logic [(1<<W_AA_REG)-1:0]  CDO_PD_pending,
    output logic [W_STALLCNT-1:0]     CDO_PD_stallcnt,
    output logic                      CFO_PV_idle
);

    localparam int N_REG = 1 << W_AA_REG;
    localparam logic [W_PD_POPS-1:0] PIPE_DPIP = W_PD_POPS'(1);
    localparam logic [W_PD_POPS-1:0] PIPE_CPIP = W_PD_POPS'(3);
    localparam logic [N_REG-1:0]     ONE_HOT0  = N_REG'(1);

    typedef enum logic [1:0] {
        ST_FLUSH  = 2'd0,
        ST_RUN    = 2'd1,
        ST_SERIAL = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [N_REG-1:0]        pending_q, pending_d;
    logic                    div_busy_q, div_busy_d;
    logic [W_STALLCNT-1:0]   stallcnt_q, stallcnt_d;

    logic [N_REG-1:0]        pend_clr;
    logic                    div_clr;
    logic                    hazard;
    logic                    div_block;
    logic                    serialize;
    logic                    issue;
    logic                    stall;

    always_comb begin
        // Writebacks and divider completion retire before this cycle's checks.
        pend_clr = pending_q;
        if (CDI_PV_wb) begin
            pend_clr = pending_q & ~(ONE_HOT0 << CDI_AA_wb);
        end
        pend_clr[0] = 1'b0;
        div_clr     = div_busy_q & ~CDI_PV_divdone;

        hazard    = pend_clr[CDI_AA_rs] | pend_clr[CDI_AA_rt] | pend_clr[CDI_AA_rd];
        div_block = (CDI_PD_piops == PIPE_DPIP) & div_clr;
        serialize = (CDI_PD_piops == PIPE_CPIP) & ((|pend_clr) | div_clr);

        issue   = 1'b0;
        stall   = 1'b0;
        state_d = state_q;
        case (state_q)
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                issue = CDI_PV_req & ~hazard & ~div_block & ~serialize & ~CFI_PC_redirect;
                stall = CDI_PV_req & ~issue & ~CFI_PC_redirect;
                if (issue && (CDI_PD_piops == PIPE_CPIP)) begin
                    state_d = ST_SERIAL;
                end
            end
            ST_SERIAL: begin
                stall = CDI_PV_req & ~CFI_PC_redirect;
                if (CDI_PV_sysdone) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_FLUSH;
            end
        endcase
        if (CFI_PC_redirect) begin
            state_d = ST_FLUSH;
        end
        if (rst) begin
            issue = 1'b0;
            stall = 1'b0;
        end

        // Set is applied after clear so a same-cycle set wins.
        pending_d = pend_clr;
        if (issue) begin
            pending_d = pend_clr | (ONE_HOT0 << CDI_AA_rd);
        end
        pending_d[0] = 1'b0;
        div_busy_d   = div_clr | (issue & (CDI_PD_piops == PIPE_DPIP));

        stallcnt_d = stallcnt_q;
        if (stall && (stallcnt_q != {W_STALLCNT{1'b1}})) begin
            stallcnt_d = stallcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FLUSH;
            pending_q  <= '0;
            div_busy_q <= 1'b0;
            stallcnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            div_busy_q <= div_busy_d;
            stallcnt_q <= stallcnt_d;
        end
    end

    assign CFO_PC_stall    = stall;
    assign CFO_PC_clear    = (state_q == ST_FLUSH);
    assign CFO_PV_issue    = issue;
    assign CFO_PD_piops    = issue ? CDI_PD_piops : '0;
    assign CDO_PD_pending  = pending_q;
    assign CDO_PD_stallcnt = stallcnt_q;
    assign CFO_PV_idle     = (pending_q == '0) & ~div_busy_q & (state_q == ST_RUN);

endmodule
